// File: rtl/hangman_pkg.sv
// hangman_pkg -- shared constants and types for the hangman datapath.
//   CHAR_W      character code width (0 = blank, A=1 .. Z=26)
//   CH_*        letter code constants
//   MAX_MISS    miss count that ends the game
//   scan_state_t  scan FSM states (IDLE, SCAN, DONE)
package hangman_pkg;

    localparam int CHAR_W   = 5;
    localparam int MAX_MISS = 6;

    localparam logic [4:0] CH_BLANK = 5'd0;
    localparam logic [4:0] CH_A = 5'd1,  CH_B = 5'd2,  CH_C = 5'd3,  CH_D = 5'd4;
    localparam logic [4:0] CH_E = 5'd5,  CH_F = 5'd6,  CH_G = 5'd7,  CH_H = 5'd8;
    localparam logic [4:0] CH_I = 5'd9,  CH_J = 5'd10, CH_K = 5'd11, CH_L = 5'd12;
    localparam logic [4:0] CH_M = 5'd13, CH_N = 5'd14, CH_O = 5'd15, CH_P = 5'd16;
    localparam logic [4:0] CH_Q = 5'd17, CH_R = 5'd18, CH_S = 5'd19, CH_T = 5'd20;
    localparam logic [4:0] CH_U = 5'd21, CH_V = 5'd22, CH_W = 5'd23, CH_X = 5'd24;
    localparam logic [4:0] CH_Y = 5'd25, CH_Z = 5'd26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/game_timer.sv
// game_timer -- round timer: prescaler plus seconds down-counter.
//   clk, resetn   clock, async active-low reset
//   clear         synchronous reload of time_left to TIME_SECS
//   run           count enable; the prescaler holds its value while low
//   time_left     seconds remaining
//   timeout       time_left has reached 0 (holds until clear/reset)
module game_timer #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int TIME_SECS = 99,
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       run,
    output logic [6:0] time_left,
    output logic       timeout
);

    logic [PW-1:0] r_pre;
    logic [6:0]    r_secs;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pre  <= '0;
            r_secs <= 7'(TIME_SECS);
        end else if (clear) begin
            r_pre  <= '0;
            r_secs <= 7'(TIME_SECS);
        end else if (run && (r_secs != 7'd0)) begin
            // counter stops on its own at zero, so timeout latches
            if (r_pre == PW'(TICK_DIV - 1)) begin
                r_pre  <= '0;
                r_secs <= r_secs - 7'd1;
            end else begin
                r_pre  <= r_pre + PW'(1);
            end
        end
    end

    assign time_left = r_secs;
    assign timeout   = (r_secs == 7'd0);

endmodule

// File: rtl/guess_datapath.sv
// guess_datapath -- hangman word store, guess scanner, counters and timer.
//   clk, resetn        clock, async active-low reset
//   clear              wipe word, mask, counters, timer (highest priority)
//   ld / compare       load next char / latch guess and scan (compare wins)
//   char_in            character for ld or compare
//   timecount          timer run enable
//   rd_addr / rd_char  display read port (blank unless revealed)
//   busy, done         scan in progress / one-cycle end-of-scan pulse
//   match, hit_count   result of last guess
//   word_len, remain, revealed, miss_count   game state
//   complete, win, timeout, time_left        game-over flags, seconds left
// Optional feature macro: GUESS_TIMER_EN (includes the game_timer instance;
// otherwise timeout = 0 and time_left = TIME_SECS).
module guess_datapath #(
    parameter int MAX_LEN   = 16,
    parameter int CHAR_W    = hangman_pkg::CHAR_W,
    parameter int MAX_MISS  = hangman_pkg::MAX_MISS,
    parameter int TICK_DIV  = 50_000_000,
    parameter int TIME_SECS = 99,
    localparam int LW = $clog2(MAX_LEN + 1),
    localparam int AW = $clog2(MAX_LEN)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               ld,
    input  logic               compare,
    input  logic [CHAR_W-1:0]  char_in,
    input  logic               timecount,
    input  logic [AW-1:0]      rd_addr,
    output logic [CHAR_W-1:0]  rd_char,
    output logic               busy,
    output logic               done,
    output logic               match,
    output logic [LW-1:0]      hit_count,
    output logic [LW-1:0]      word_len,
    output logic [LW-1:0]      remain,
    output logic [MAX_LEN-1:0] revealed,
    output logic [2:0]         miss_count,
    output logic               complete,
    output logic               win,
    output logic               timeout,
    output logic [6:0]         time_left
);

    import hangman_pkg::*;

    scan_state_t r_state, w_state_nxt;

    logic [MAX_LEN-1:0][CHAR_W-1:0] r_word;
    logic [MAX_LEN-1:0]             r_revealed;
    logic [LW-1:0]                  r_word_len, r_remain, r_hit_count;
    logic [AW-1:0]                  r_idx;
    logic [CHAR_W-1:0]              r_guess;
    logic                           r_any, r_match;
    logic [2:0]                     r_miss;

    logic w_game_over, w_cmp_acc, w_ld_acc, w_hit_here, w_last, w_any_final;

    assign w_game_over = complete | win | timeout;
    assign w_cmp_acc   = compare & (r_state == IDLE) & ~w_game_over;
    assign w_ld_acc    = ld & ~compare & (r_state == IDLE) & ~w_game_over
                       & (r_word_len < LW'(MAX_LEN));
    assign w_hit_here  = (r_word[r_idx] == r_guess);
    assign w_last      = ((LW'(r_idx) + LW'(1)) == r_word_len);
    // result of the whole scan, including the position examined this cycle
    assign w_any_final = r_any | w_hit_here;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_cmp_acc) w_state_nxt = (r_word_len == '0) ? DONE : SCAN;
                SCAN:    if (w_last)    w_state_nxt = DONE;
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_word      <= '0;
            r_revealed  <= '0;
            r_word_len  <= '0;
            r_remain    <= '0;
            r_hit_count <= '0;
            r_idx       <= '0;
            r_guess     <= '0;
            r_any       <= 1'b0;
            r_match     <= 1'b0;
            r_miss      <= '0;
        end else if (clear) begin
            r_word      <= '0;
            r_revealed  <= '0;
            r_word_len  <= '0;
            r_remain    <= '0;
            r_hit_count <= '0;
            r_idx       <= '0;
            r_guess     <= '0;
            r_any       <= 1'b0;
            r_match     <= 1'b0;
            r_miss      <= '0;
        end else begin
            if (w_ld_acc) begin
                r_word[r_word_len[AW-1:0]] <= char_in;
                r_word_len <= r_word_len + LW'(1);
                r_remain   <= r_remain + LW'(1);
            end
            if (w_cmp_acc) begin
                r_guess     <= char_in;
                r_hit_count <= '0;
                r_idx       <= '0;
                r_any       <= 1'b0;
                // empty word skips SCAN, so the result is settled here
                if (r_word_len == '0) r_match <= 1'b0;
            end
            if (r_state == SCAN) begin
                r_idx <= r_idx + AW'(1);
                if (w_hit_here) begin
                    r_any <= 1'b1;
                    if (!r_revealed[r_idx]) begin
                        r_revealed[r_idx] <= 1'b1;
                        r_hit_count       <= r_hit_count + LW'(1);
                        r_remain          <= r_remain - LW'(1);
                    end
                end
                // match/miss land on the edge into DONE so they are valid with done
                if (w_last) begin
                    r_match <= w_any_final;
                    if (!w_any_final) r_miss <= r_miss + 3'd1;
                end
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign match      = r_match;
    assign hit_count  = r_hit_count;
    assign word_len   = r_word_len;
    assign remain     = r_remain;
    assign revealed   = r_revealed;
    assign miss_count = r_miss;
    assign complete   = (r_miss == 3'(MAX_MISS));
    assign win        = (r_word_len != '0) && (r_remain == '0);
    assign rd_char    = r_revealed[rd_addr] ? r_word[rd_addr] : '0;

`ifdef GUESS_TIMER_EN
    logic w_timer_run;
    assign w_timer_run = timecount & ~win & ~complete;

    game_timer #(
        .TICK_DIV  (TICK_DIV),
        .TIME_SECS (TIME_SECS)
    ) u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .run       (w_timer_run),
        .time_left (time_left),
        .timeout   (timeout)
    );
`else
    logic w_unused_timecount;
    assign w_unused_timecount = timecount;
    assign time_left = 7'(TIME_SECS);
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_guess_datapath.sv
// tb_guess_datapath -- directed plus randomized bench for guess_datapath with
// a transaction-level game model and a per-cycle compare process.
module tb_guess_datapath;
    import hangman_pkg::*;

    localparam int ML = 16;
    localparam int TD = 4;
    localparam int TS = 3;

    logic        clk = 1'b0, resetn = 1'b0, clear = 1'b0, ld = 1'b0, compare = 1'b0, timecount = 1'b0;
    logic [4:0]  char_in = '0;
    logic [3:0]  rd_addr = '0;
    logic [4:0]  rd_char;
    logic        busy, done, match, complete, win, timeout;
    logic [4:0]  hit_count, word_len, remain;
    logic [15:0] revealed;
    logic [2:0]  miss_count;
    logic [6:0]  time_left;

    guess_datapath #(.MAX_LEN(ML), .CHAR_W(5), .MAX_MISS(6), .TICK_DIV(TD), .TIME_SECS(TS)) dut (
        .clk(clk), .resetn(resetn), .clear(clear), .ld(ld), .compare(compare),
        .char_in(char_in), .timecount(timecount), .rd_addr(rd_addr), .rd_char(rd_char),
        .busy(busy), .done(done), .match(match), .hit_count(hit_count),
        .word_len(word_len), .remain(remain), .revealed(revealed),
        .miss_count(miss_count), .complete(complete), .win(win),
        .timeout(timeout), .time_left(time_left));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---- game model: one entry per stored character, results resolved at compare time
    int        cyc = 0;
    int        m_word[ML];
    int        m_len, m_miss, m_hit, p_miss, p_hit;
    bit [15:0] m_rev, p_rev;
    bit        m_match, p_match;
    int        m_done_at, m_win_from, m_runcyc;

    function automatic int remain_vis();
        return m_len - $countones(m_rev);
    endfunction

    function automatic bit win_at(input int k);
        return (m_len != 0 && remain_vis() == 0) || (k >= m_win_from);
    endfunction

    function automatic int secs_exp();
`ifdef GUESS_TIMER_EN
        return TS - m_runcyc / TD;
`else
        return TS;
`endif
    endfunction

    task automatic model_clear();
        foreach (m_word[j]) m_word[j] = 0;
        m_len = 0; m_rev = '0; p_rev = '0; m_miss = 0; p_miss = 0;
        m_hit = 0; p_hit = 0; m_match = 0; p_match = 0;
        m_done_at = -1; m_win_from = 1 << 30; m_runcyc = 0;
    endtask

    task automatic model_edge();
        int  prev, L, hits, jmax;
        bit  go, tmo, idle, any;
        prev = cyc;
        cyc++;
        tmo  = (secs_exp() == 0);
        go   = (m_miss == 6) || win_at(prev) || tmo;
        idle = (prev > m_done_at);
        if (clear) begin
            model_clear();
            return;
        end
`ifdef GUESS_TIMER_EN
        if (timecount && !win_at(prev) && m_miss != 6 && !tmo) m_runcyc++;
`endif
        if (compare && idle && !go) begin
            L = m_len; any = 0; hits = 0; jmax = -1; p_rev = m_rev;
            for (int j = 0; j < L; j++) begin
                if (m_word[j] == int'(char_in)) begin
                    any = 1;
                    if (!m_rev[j]) begin p_rev[j] = 1'b1; hits++; jmax = j; end
                end
            end
            p_hit = hits; p_match = any;
            p_miss = m_miss + ((L > 0 && !any) ? 1 : 0);
            m_done_at = cyc + L;
            // position j becomes visible one cycle after it is scanned
            if (jmax >= 0 && (L - $countones(p_rev)) == 0) m_win_from = cyc + 1 + jmax;
        end else if (ld && !compare && idle && !go && m_len < ML) begin
            m_word[m_len] = int'(char_in);
            m_len++;
        end
        if (cyc == m_done_at) begin
            m_rev = p_rev; m_hit = p_hit; m_match = p_match; m_miss = p_miss;
        end
    endtask

    // ---- compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, cyc <= m_done_at);
            chk("done", done, cyc == m_done_at);
            chk("word_len", word_len, m_len);
            chk("complete", complete, m_miss == 6);
            chk("win", win, win_at(cyc));
            chk("time_left", time_left, secs_exp());
            chk("timeout", timeout, secs_exp() == 0);
            if (cyc > m_done_at || cyc == m_done_at) begin
                chk("remain", remain, remain_vis());
                chk("revealed", revealed, m_rev);
                chk("miss_count", miss_count, m_miss);
                chk("match", match, m_match);
                chk("hit_count", hit_count, m_hit);
                chk("rd_char", rd_char, m_rev[rd_addr] ? m_word[rd_addr] : 0);
            end
        end
    end

    // ---- stimulus helpers (called at posedge+1)
    task automatic step(input bit l, input bit c, input bit cl, input bit tc, input int ch, input int ra);
        ld = l; compare = c; clear = cl; timecount = tc;
        char_in = 5'(ch); rd_addr = 4'(ra);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input int ch);
        step(1, 0, 0, 0, ch, 0);
    endtask

    // lat counts the compare cycle as 1
    task automatic do_cmp(input int g, output int lat);
        step(0, 1, 0, 0, g, 0);
        lat = 1;
        while (!done && lat < 40) begin
            step(0, 0, 0, 0, 0, 0);
            lat++;
        end
        if (!done) chk("done_wait", done, 1);
    endtask

    task automatic no_scan(input string nm, input int g);
        int seen;
        seen = 0;
        step(0, 1, 0, 0, g, 0);
        for (int k = 0; k < 6; k++) begin
            if (busy || done) seen++;
            step(0, 0, 0, 0, 0, 0);
        end
        chk(nm, seen, 0);
    endtask

    initial begin
        int lat;
        int r, ch, ra;
        bit tc;
        model_clear();
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_word_len", word_len, 0);
        chk("rst_revealed", revealed, 0);
        chk("rst_time_left", time_left, TS);
        chk("rst_timeout", timeout, 0);
        chk("rst_rd_char", rd_char, 0);
        #1 resetn = 1'b1;
        chk_en = 1'b1;

        // word load and first hit
        step(0, 0, 1, 0, 0, 0);
        load(CH_C); load(CH_A); load(CH_T);
        chk("len_cat", word_len, 3);
        do_cmp(CH_A, lat);
        chk("lat_a", lat, 4);
        chk("match_a", match, 1);
        chk("hit_a", hit_count, 1);
        chk("rev_a", revealed, 16'h0002);
        chk("remain_a", remain, 2);
        step(0, 0, 0, 0, 0, 1);
        chk("rd_char1", rd_char, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("rd_char0", rd_char, 0);

        // repeat and miss
        do_cmp(CH_A, lat);
        chk("match_rep", match, 1);
        chk("hit_rep", hit_count, 0);
        chk("miss_rep", miss_count, 0);
        idle(1);
        do_cmp(CH_Z, lat);
        chk("match_z", match, 0);
        chk("miss_z", miss_count, 1);
        idle(1);

        // win
        do_cmp(CH_C, lat);
        chk("win_c", win, 0);
        idle(1);
        do_cmp(CH_T, lat);
        chk("win_t", win, 1);
        chk("remain_t", remain, 0);
        idle(1);
        no_scan("no_done_after_win", CH_X);

        // loss
        step(0, 0, 1, 0, 0, 0);
        load(CH_D); load(CH_O); load(CH_G);
        do_cmp(CH_Z, lat); idle(1);
        do_cmp(CH_Y, lat); idle(1);
        do_cmp(CH_X, lat); idle(1);
        do_cmp(CH_W, lat); idle(1);
        do_cmp(CH_V, lat);
        chk("complete_5", complete, 0);
        idle(1);
        do_cmp(CH_U, lat);
        chk("complete_6", complete, 1);
        chk("miss_6", miss_count, 6);
        idle(1);
        no_scan("no_done_after_loss", CH_D);

        // overflow, then clear mid-scan
        step(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 17; k++) load((k % 5) + 1);
        chk("len_full", word_len, 16);
        step(0, 1, 0, 0, 1, 0);
        idle(2);
        chk("busy_scan", busy, 1);
        step(0, 0, 1, 0, 0, 0);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_len", word_len, 0);
        chk("clr_rev", revealed, 0);
        chk("clr_hit", hit_count, 0);
        idle(3);

        // timer
        step(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 0, 0);
`ifdef GUESS_TIMER_EN
        chk("tl_12", time_left, 0);
        chk("tmo_12", timeout, 1);
        step(0, 1, 0, 0, 1, 0);
        chk("cmp_tmo_ignored", busy, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("tl_clr", time_left, 3);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 0, 0);
        chk("tl_6", time_left, 2);
        idle(5);
        chk("tl_frozen", time_left, 2);
        for (int k = 0; k < 2; k++) step(0, 0, 0, 1, 0, 0);
        chk("tl_resume", time_left, 1);
`else
        chk("tl_off", time_left, TS);
        chk("tmo_off", timeout, 0);
`endif

        // randomized play
        step(0, 0, 1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            r  = $urandom_range(0, 99);
            ch = $urandom_range(1, 8);
            tc = 1'($urandom_range(0, 1));
            ra = $urandom_range(0, 15);
            if (r < 30)      step(1, 0, 0, tc, (ch % 5) + 1, ra);
            else if (r < 45) step(0, 1, 0, tc, ch, ra);
            else if (r < 47) step(0, 0, 1, tc, ch, ra);
            else             step(0, 0, 0, tc, ch, ra);
        end

        // asynchronous reset in the middle of a scan
        step(0, 0, 1, 0, 0, 0);
        load(CH_B); load(CH_E); load(CH_E);
        step(0, 1, 0, 0, CH_E, 0);
        idle(1);
        #1 resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_len", word_len, 0);
        chk("arst_rev", revealed, 0);
        chk("arst_miss", miss_count, 0);
        chk("arst_time_left", time_left, TS);
        model_clear();
        #1 resetn = 1'b1;
        load(CH_A);
        do_cmp(CH_A, lat);
        chk("post_rst_lat", lat, 2);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/guess_datapath.md
# guess_datapath

Datapath for the hangman game, directly downstream of the game-control FSM. Stores the secret word loaded character by character. On each compare command it scans the stored word against the latched guess, updates the revealed mask and the hit and miss counters, and runs the round timer. It returns match, complete and timeout feedback to the FSM and exposes word and mask state to the display stage.

## Interface
Parameters:
- MAX_LEN, 16: maximum word length in characters.
- CHAR_W, 5: character code width. Code 0 is reserved as blank; A=1 … Z=26.
- MAX_MISS, 6: miss count that ends the game.
- TICK_DIV, 50_000_000: clk cycles per timer second.
- TIME_SECS, 99: round length in seconds.

Ports (LW = $clog2(MAX_LEN+1)):
- clk, in, 1: single clock, rising edge.
- resetn, in, 1: asynchronous active-low reset.
- clear, in, 1: synchronous wipe of word, mask, counters and timer.
- ld, in, 1: write char_in as the next word character.
- compare, in, 1: latch char_in as the guess and start a scan.
- char_in, in, CHAR_W: character for ld or compare.
- timecount, in, 1: timer run enable.
- rd_addr, in, $clog2(MAX_LEN): display read address.
- rd_char, out, CHAR_W: stored character at rd_addr if revealed, else 0.
- busy, out, 1: scan in progress.
- done, out, 1: one-cycle pulse at the end of a scan.
- match, out, 1: the last guess equals at least one stored character.
- hit_count, out, LW: positions newly revealed by the last guess.
- word_len, out, LW: number of characters loaded.
- remain, out, LW: unrevealed positions.
- revealed, out, MAX_LEN: per-position reveal mask.
- miss_count, out, 3: wrong guesses so far.
- complete, out, 1: miss_count == MAX_MISS.
- win, out, 1: word_len != 0 and remain == 0.
- timeout, out, 1: time_left has reached 0.
- time_left, out, 7: seconds remaining.

## Operation
- State machine:
  - IDLE: a compare that is accepted latches the guess, clears hit_count and the scan index, and moves to SCAN.
  - SCAN: examines index i each cycle. If word[i] == guess, the internal any-match flag is set. If additionally revealed[i] == 0, revealed[i] is set, hit_count increments and remain decrements. After i == word_len-1, moves to DONE.
  - DONE: done=1, match=any-match. miss_count increments if any-match is 0. Returns to IDLE.
- Guessing an already-revealed letter gives match=1 and hit_count=0. It is not a miss.
- ld:
  - Accepted only in IDLE with word_len < MAX_LEN.
  - Writes word[word_len] and increments word_len and remain.
  - Ignored otherwise: full, busy, or game over.
- compare:
  - Ignored while busy, and when complete, win or timeout is set.
  - With word_len == 0 the FSM goes straight to DONE: match=0, no miss.
- clear:
  - Highest priority, in any state. Aborts a scan without a done pulse.
  - Zeros word_len, remain, revealed, miss_count, hit_count and match. Reloads time_left to TIME_SECS. Returns to IDLE.
  - Stored characters are zeroed.
- ld and compare in the same cycle: compare wins and ld is dropped.
- Timer:
  - A prescaler counts clk cycles while timecount is high and win, complete and timeout are all 0.
  - At TICK_DIV-1 the prescaler wraps and time_left decrements.
  - timeout goes high when time_left reaches 0 and holds until clear or reset.
  - The prescaler holds its value while disabled.

## Timing
- Reset values:
  - All outputs 0, except time_left = TIME_SECS.
  - State IDLE, word storage zeroed.
- Scan timing, for compare sampled at edge N with word_len = L:
  - busy is high from N+1 through N+L+1.
  - done is high in cycle N+L+1 (DONE state), with match, hit_count, miss_count, remain and revealed already updated.
  - The next compare can be accepted at edge N+L+2.
- ld takes effect at the next edge. word_len and rd_char reflect it one cycle later.
- rd_char is combinational from rd_addr, the word storage and revealed.
- complete, win and timeout are combinational from their registered counters, so they are valid in the same cycle as the done that caused them.

## Configuration
- GUESS_TIMER_EN:
  - Defined: the game_timer instance is present as described above.
  - Undefined: no timer logic. timeout is tied 0, time_left is tied to TIME_SECS, and timecount is ignored.

## Structure
- Package hangman_pkg holds:
  - CHAR_W, the blank code 0 and the letter code constants.
  - MAX_MISS.
  - The scan-state enum (IDLE, SCAN, DONE).
- Sub-module game_timer contains the prescaler, the seconds down-counter and timeout. Its ports are clk, resetn, clear, run, time_left and timeout.

## Test plan
- Word load and hit: load C(3), A(1), T(20), then compare A.
  - done exactly 4 cycles after compare.
  - match=1, hit_count=1, revealed=…010, remain=2, rd_char[1]=1, rd_char[0]=0.
- Repeat and miss: after the above, compare A again, then compare Z(26).
  - First: match=1, hit_count=0, miss_count=0.
  - Second: match=0, miss_count=1.
- Win and loss:
  - Guess C and T: win=1; a further compare gives no done.
  - New word, six wrong guesses: complete=1 on the sixth done; the seventh compare is ignored.
- Timer, with TICK_DIV=4, TIME_SECS=3:
  - timecount high for 12 cycles gives time_left 3→0 and timeout=1.
  - Dropping timecount mid-count freezes time_left.
  - clear restores time_left to 3.
- Overflow and priority:
  - 17 ld pulses give word_len=16.
  - clear asserted during SCAN: no done, busy=0 next cycle, all counters 0.
- resetn pulsed low mid-scan (asynchronous): outputs go to their reset values immediately; time_left=TIME_SECS.
